ddr_arbiter: RTL and testbench

- Shares the single DDR burst port (rd/wr/addr/mask/din/dout/waitReq/valid/burstCount) between two requesters: requester 0 (ROM download/upload loader) and requester 1 (frame buffer writer/reader).
- Sits inside the fast (system) clock domain, between the requesters and the top-level DDRAM pins.
- Arbitrates round-robin at burst granularity and locks the port to one owner until its read or write burst completes.

---
 rtl/ddr_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ddr_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// ddr_arbiter
// Shares one DDR burst port between requester 0 (ROM loader) and requester 1
// (frame buffer). Grants are round-robin at burst granularity. Once a burst is
// accepted, the port stays locked to that requester until the burst finishes:
// all read beats have returned, or all write beats have been accepted.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   inN_rd / inN_wr       read request / write beat request from requester N
//   inN_addr              burst start address
//   inN_burstCount        beats in burst (0 is treated as 1)
//   inN_mask / inN_din    byte enables / write data
//   inN_waitReq           stall to requester N
//   inN_valid             read beat valid to requester N
//   inN_dout              read data (ddr_dout broadcast to both)
//   ddr_*                 DDR burst port
//   busy                  high while a multi-cycle burst owns the port
module ddr_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      in0_rd,
    input  logic                      in0_wr,
    input  logic [ADDR_WIDTH-1:0]     in0_addr,
    input  logic [BURST_WIDTH-1:0]    in0_burstCount,
    input  logic [DATA_WIDTH/8-1:0]   in0_mask,
    input  logic [DATA_WIDTH-1:0]     in0_din,
    output logic                      in0_waitReq,
    output logic                      in0_valid,
    output logic [DATA_WIDTH-1:0]     in0_dout,

    input  logic                      in1_rd,
    input  logic                      in1_wr,
    input  logic [ADDR_WIDTH-1:0]     in1_addr,
    input  logic [BURST_WIDTH-1:0]    in1_burstCount,
    input  logic [DATA_WIDTH/8-1:0]   in1_mask,
    input  logic [DATA_WIDTH-1:0]     in1_din,
    output logic                      in1_waitReq,
    output logic                      in1_valid,
    output logic [DATA_WIDTH-1:0]     in1_dout,

    output logic                      ddr_rd,
    output logic                      ddr_wr,
    output logic [ADDR_WIDTH-1:0]     ddr_addr,
    output logic [BURST_WIDTH-1:0]    ddr_burstCount,
    output logic [DATA_WIDTH/8-1:0]   ddr_mask,
    output logic [DATA_WIDTH-1:0]     ddr_din,
    input  logic [DATA_WIDTH-1:0]     ddr_dout,
    input  logic                      ddr_waitReq,
    input  logic                      ddr_valid,

    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_WAIT   = 2'd1,
        WRITE_BURST = 2'd2
    } state_t;

    localparam logic [BURST_WIDTH-1:0] C_ZERO = {BURST_WIDTH{1'b0}};
    localparam logic [BURST_WIDTH-1:0] C_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    state_t                   r_state;
    logic                     r_owner;
    logic                     r_last;
    logic [BURST_WIDTH-1:0]   r_beats;

    logic                     w_req0;
    logic                     w_req1;
    logic                     w_any;
    logic                     w_sel;
    logic                     w_src;
    logic                     w_src_rd;
    logic                     w_src_wr;
    logic [BURST_WIDTH-1:0]   w_src_bc;
    logic [BURST_WIDTH-1:0]   w_bc_eff;
    logic                     w_accept;

    assign w_req0 = in0_rd | in0_wr;
    assign w_req1 = in1_rd | in1_wr;
    assign w_any  = w_req0 | w_req1;

    // On a tie the requester that was not granted last wins; with no request
    // the selection rests on requester 0 so its addr/data are forwarded.
    assign w_sel = (w_req0 & w_req1) ? ~r_last : w_req1;

    // Datapath source: the arbitration winner while idle, the owner otherwise.
    assign w_src = (r_state == IDLE) ? w_sel : r_owner;

    assign w_src_rd       = w_src ? in1_rd         : in0_rd;
    assign w_src_wr       = w_src ? in1_wr         : in0_wr;
    assign w_src_bc       = w_src ? in1_burstCount : in0_burstCount;
    assign ddr_addr       = w_src ? in1_addr       : in0_addr;
    assign ddr_burstCount = w_src_bc;
    assign ddr_mask       = w_src ? in1_mask       : in0_mask;
    assign ddr_din        = w_src ? in1_din        : in0_din;

    // A zero burst count is illegal and behaves as a single beat.
    assign w_bc_eff = (w_src_bc == C_ZERO) ? C_ONE : w_src_bc;

    assign w_accept = (ddr_rd | ddr_wr) & ~ddr_waitReq;

    assign in0_dout = ddr_dout;
    assign in1_dout = ddr_dout;
    assign busy     = (r_state != IDLE);

    // Command, stall and read-valid steering for the current state.
    always_comb begin
        ddr_rd      = 1'b0;
        ddr_wr      = 1'b0;
        in0_waitReq = 1'b1;
        in1_waitReq = 1'b1;
        in0_valid   = 1'b0;
        in1_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    // rd wins over wr when both are raised by one requester
                    ddr_rd = w_src_rd;
                    ddr_wr = w_src_wr & ~w_src_rd;
                    if (w_sel) begin
                        in1_waitReq = ddr_waitReq;
                    end else begin
                        in0_waitReq = ddr_waitReq;
                    end
                end else begin
                    ddr_rd = 1'b0;
                    ddr_wr = 1'b0;
                end
            end
            READ_WAIT: begin
                if (r_owner) begin
                    in1_valid = ddr_valid;
                end else begin
                    in0_valid = ddr_valid;
                end
            end
            WRITE_BURST: begin
                ddr_wr = w_src_wr;
                if (r_owner) begin
                    in1_waitReq = ddr_waitReq;
                end else begin
                    in0_waitReq = ddr_waitReq;
                end
            end
            default: begin
                ddr_rd = 1'b0;
                ddr_wr = 1'b0;
            end
        endcase
    end

    // Grant/lock state machine and remaining-beat counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_beats <= C_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_sel;
                        r_last  <= w_sel;
                        if (ddr_rd) begin
                            r_state <= READ_WAIT;
                            r_beats <= w_bc_eff;
                        end else if (w_src_bc > C_ONE) begin
                            // first beat went out with the command
                            r_state <= WRITE_BURST;
                            r_beats <= w_src_bc - C_ONE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                READ_WAIT: begin
                    if (ddr_valid) begin
                        r_beats <= r_beats - C_ONE;
                        if (r_beats == C_ONE) begin
                            r_state <= IDLE;
                        end
                    end
                end
                WRITE_BURST: begin
                    if (w_accept) begin
                        r_beats <= r_beats - C_ONE;
                        if (r_beats == C_ONE) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
module tb_ddr_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  q_rd;
    logic [1:0]  q_wr;
    logic [31:0] q_addr [2];
    logic [7:0]  q_bc   [2];
    logic [7:0]  q_mask [2];
    logic [63:0] q_din  [2];
    logic [1:0]  o_wait;
    logic [1:0]  o_valid;
    logic [63:0] o_dout [2];

    logic        ddr_rd;
    logic        ddr_wr;
    logic [31:0] ddr_addr;
    logic [7:0]  ddr_burstCount;
    logic [7:0]  ddr_mask;
    logic [63:0] ddr_din;
    logic [63:0] ddr_dout;
    logic        ddr_waitReq;
    logic        ddr_valid;
    logic        busy;

    int total;
    int bad;

    ddr_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .in0_rd         (q_rd[0]),
        .in0_wr         (q_wr[0]),
        .in0_addr       (q_addr[0]),
        .in0_burstCount (q_bc[0]),
        .in0_mask       (q_mask[0]),
        .in0_din        (q_din[0]),
        .in0_waitReq    (o_wait[0]),
        .in0_valid      (o_valid[0]),
        .in0_dout       (o_dout[0]),
        .in1_rd         (q_rd[1]),
        .in1_wr         (q_wr[1]),
        .in1_addr       (q_addr[1]),
        .in1_burstCount (q_bc[1]),
        .in1_mask       (q_mask[1]),
        .in1_din        (q_din[1]),
        .in1_waitReq    (o_wait[1]),
        .in1_valid      (o_valid[1]),
        .in1_dout       (o_dout[1]),
        .ddr_rd         (ddr_rd),
        .ddr_wr         (ddr_wr),
        .ddr_addr       (ddr_addr),
        .ddr_burstCount (ddr_burstCount),
        .ddr_mask       (ddr_mask),
        .ddr_din        (ddr_din),
        .ddr_dout       (ddr_dout),
        .ddr_waitReq    (ddr_waitReq),
        .ddr_valid      (ddr_valid),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The port is either free, or held by one owner for a read (counting
    // returned beats) or a write (counting beats still to be accepted).
    typedef enum {M_IDLE, M_READ, M_WRITE} mphase_t;
    mphase_t m_phase;
    int      m_owner;
    int      m_last;
    int      m_left;

    function automatic logic m_req(input int k);
        return q_rd[k] | q_wr[k];
    endfunction

    function automatic logic m_any();
        return m_req(0) | m_req(1);
    endfunction

    function automatic int m_pick();
        if (m_req(0) && m_req(1)) return 1 - m_last;
        else if (m_req(1)) return 1;
        else return 0;
    endfunction

    function automatic logic m_erd();
        return m_any() && q_rd[m_pick()];
    endfunction

    function automatic logic m_ewr();
        return m_any() && q_wr[m_pick()] && !q_rd[m_pick()];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= M_IDLE;
            m_owner <= 0;
            m_last  <= 1;
            m_left  <= 0;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    if ((m_erd() || m_ewr()) && !ddr_waitReq) begin
                        m_owner <= m_pick();
                        m_last  <= m_pick();
                        if (m_erd()) begin
                            m_phase <= M_READ;
                            m_left  <= (q_bc[m_pick()] == 8'd0) ? 1 : int'(q_bc[m_pick()]);
                        end else if (q_bc[m_pick()] > 8'd1) begin
                            m_phase <= M_WRITE;
                            m_left  <= int'(q_bc[m_pick()]) - 1;
                        end
                    end
                end
                M_READ: begin
                    if (ddr_valid) begin
                        m_left <= m_left - 1;
                        if (m_left <= 1) m_phase <= M_IDLE;
                    end
                end
                M_WRITE: begin
                    if (q_wr[m_owner] && !ddr_waitReq) begin
                        m_left <= m_left - 1;
                        if (m_left <= 1) m_phase <= M_IDLE;
                    end
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every meaningful DUT output against the model.
    always @(negedge clock) begin : cmp
        int p;
        #2;
        chk("dout0", o_dout[0], ddr_dout);
        chk("dout1", o_dout[1], ddr_dout);
        chk("busy", 64'(busy), 64'(m_phase != M_IDLE));
        case (m_phase)
            M_IDLE: begin
                p = m_pick();
                chk("m_rd", 64'(ddr_rd), 64'(m_erd()));
                chk("m_wr", 64'(ddr_wr), 64'(m_ewr()));
                chk("m_addr", 64'(ddr_addr), 64'(q_addr[p]));
                chk("m_bc", 64'(ddr_burstCount), 64'(q_bc[p]));
                chk("m_mask", 64'(ddr_mask), 64'(q_mask[p]));
                chk("m_din", ddr_din, q_din[p]);
                for (int k = 0; k < 2; k++) begin
                    chk("m_wait_idle", 64'(o_wait[k]),
                        64'((m_any() && p == k) ? ddr_waitReq : 1'b1));
                    chk("m_valid_idle", 64'(o_valid[k]), 64'd0);
                end
            end
            M_READ: begin
                chk("m_rd_r", 64'(ddr_rd), 64'd0);
                chk("m_wr_r", 64'(ddr_wr), 64'd0);
                for (int k = 0; k < 2; k++) begin
                    chk("m_wait_r", 64'(o_wait[k]), 64'd1);
                    chk("m_valid_r", 64'(o_valid[k]),
                        64'((k == m_owner) ? ddr_valid : 1'b0));
                end
            end
            M_WRITE: begin
                chk("m_rd_w", 64'(ddr_rd), 64'd0);
                chk("m_wr_w", 64'(ddr_wr), 64'(q_wr[m_owner]));
                chk("m_addr_w", 64'(ddr_addr), 64'(q_addr[m_owner]));
                chk("m_bc_w", 64'(ddr_burstCount), 64'(q_bc[m_owner]));
                chk("m_mask_w", 64'(ddr_mask), 64'(q_mask[m_owner]));
                chk("m_din_w", ddr_din, q_din[m_owner]);
                for (int k = 0; k < 2; k++) begin
                    chk("m_wait_w", 64'(o_wait[k]),
                        64'((k == m_owner) ? ddr_waitReq : 1'b1));
                    chk("m_valid_w", 64'(o_valid[k]), 64'd0);
                end
            end
            default: chk("m_phase", 64'd0, 64'd1);
        endcase
    end

    task automatic idle_inputs();
        q_rd = 2'b00;
        q_wr = 2'b00;
        for (int k = 0; k < 2; k++) begin
            q_addr[k] = 32'h0;
            q_bc[k]   = 8'd1;
            q_mask[k] = 8'hFF;
            q_din[k]  = 64'h0;
        end
        ddr_waitReq = 1'b0;
        ddr_valid   = 1'b0;
        ddr_dout    = 64'h0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int beat;
        int stalled;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clock);
        #2;
        chk("rst_rd", 64'(ddr_rd), 64'd0);
        chk("rst_wr", 64'(ddr_wr), 64'd0);
        chk("rst_wait0", 64'(o_wait[0]), 64'd1);
        chk("rst_wait1", 64'(o_wait[1]), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // single read from in1, 4 beats
        @(negedge clock);
        q_rd[1] = 1'b1; q_addr[1] = 32'h100; q_bc[1] = 8'd4;
        #2;
        chk("sr_rd", 64'(ddr_rd), 64'd1);
        chk("sr_addr", 64'(ddr_addr), 64'h100);
        chk("sr_bc", 64'(ddr_burstCount), 64'd4);
        chk("sr_wait1", 64'(o_wait[1]), 64'd0);
        @(negedge clock);
        q_rd[1] = 1'b0;
        #2;
        chk("sr_rd_pulse", 64'(ddr_rd), 64'd0);
        chk("sr_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ddr_valid = 1'b1; ddr_dout = 64'hD0 + 64'(i);
            #2;
            chk("sr_valid1", 64'(o_valid[1]), 64'd1);
            chk("sr_dout1", o_dout[1], 64'hD0 + 64'(i));
            chk("sr_valid0", 64'(o_valid[0]), 64'd0);
        end
        @(negedge clock);
        ddr_valid = 1'b0;
        #2;
        chk("sr_busy_drop", 64'(busy), 64'd0);
        chk("sr_valid_end", 64'(o_valid[1]), 64'd0);

        // contention from reset: 1-beat writes from both
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        q_wr = 2'b11; q_bc[0] = 8'd1; q_bc[1] = 8'd1;
        q_addr[0] = 32'hA0; q_addr[1] = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("ct_wr", 64'(ddr_wr), 64'd1);
            chk("ct_addr", 64'(ddr_addr), (i % 2 == 1) ? 64'hB0 : 64'hA0);
            chk("ct_wait_loser", 64'(o_wait[(i % 2 == 1) ? 0 : 1]), 64'd1);
            @(negedge clock);
        end
        q_wr = 2'b00;

        // 8-beat write from in0 with stalls on beats 3 and 6; in1 reads mid-burst
        @(negedge clock);
        q_wr[0] = 1'b1; q_addr[0] = 32'h200; q_bc[0] = 8'd8;
        beat = 1; stalled = 0;
        for (int c = 0; c < 30 && beat <= 8; c++) begin
            q_din[0] = 64'(beat);
            ddr_waitReq = ((beat == 3 || beat == 6) && stalled == 0);
            if (c == 2) begin
                q_rd[1] = 1'b1; q_addr[1] = 32'h300; q_bc[1] = 8'd2;
            end
            #2;
            chk("wb_wr", 64'(ddr_wr), 64'd1);
            chk("wb_din", ddr_din, 64'(beat));
            chk("wb_addr", 64'(ddr_addr), 64'h200);
            chk("wb_rd", 64'(ddr_rd), 64'd0);
            chk("wb_wait1", 64'(o_wait[1]), 64'd1);
            if (ddr_waitReq) stalled = 1;
            else begin beat++; stalled = 0; end
            @(negedge clock);
        end
        chk("wb_beats", 64'(beat), 64'd9);
        q_wr[0] = 1'b0; ddr_waitReq = 1'b0;
        #2;
        chk("wb_in1_grant", 64'(ddr_rd), 64'd1);
        chk("wb_in1_addr", 64'(ddr_addr), 64'h300);
        chk("wb_in1_wait", 64'(o_wait[1]), 64'd0);
        @(negedge clock);
        q_rd[1] = 1'b0; ddr_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        ddr_valid = 1'b0;

        // read burst 2 from in0 outstanding while in1 wants to write
        @(negedge clock);
        q_rd[0] = 1'b1; q_addr[0] = 32'h500; q_bc[0] = 8'd2;
        #2;
        chk("rb_rd", 64'(ddr_rd), 64'd1);
        @(negedge clock);
        q_rd[0] = 1'b0; q_wr[1] = 1'b1; q_addr[1] = 32'h400; q_bc[1] = 8'd1;
        #2;
        chk("rb_wait1_a", 64'(o_wait[1]), 64'd1);
        chk("rb_wr_a", 64'(ddr_wr), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            ddr_valid = 1'b1;
            #2;
            chk("rb_valid0", 64'(o_valid[0]), 64'd1);
            chk("rb_wait1", 64'(o_wait[1]), 64'd1);
            chk("rb_wr", 64'(ddr_wr), 64'd0);
        end
        @(negedge clock);
        ddr_valid = 1'b0;
        #2;
        chk("rb_in1_wr", 64'(ddr_wr), 64'd1);
        chk("rb_in1_addr", 64'(ddr_addr), 64'h400);
        chk("rb_in1_wait", 64'(o_wait[1]), 64'd0);
        @(negedge clock);
        q_wr[1] = 1'b0;

        // reset in the middle of a 4-beat read
        @(negedge clock);
        q_rd[0] = 1'b1; q_addr[0] = 32'h600; q_bc[0] = 8'd4;
        #2;
        chk("rm_rd", 64'(ddr_rd), 64'd1);
        @(negedge clock);
        q_rd[0] = 1'b0; ddr_valid = 1'b1;
        #2;
        chk("rm_valid0", 64'(o_valid[0]), 64'd1);
        @(negedge clock);
        ddr_valid = 1'b0; reset = 1'b1;
        #2;
        chk("rm_busy_rst", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            ddr_valid = 1'b1;
            #2;
            chk("rm_stale_valid", 64'(o_valid), 64'd0);
            chk("rm_busy", 64'(busy), 64'd0);
        end
        @(negedge clock);
        ddr_valid = 1'b0;

        // burstCount 0 read returns a single beat
        q_rd[1] = 1'b1; q_addr[1] = 32'h700; q_bc[1] = 8'd0;
        #2;
        chk("bz_rd", 64'(ddr_rd), 64'd1);
        @(negedge clock);
        q_rd[1] = 1'b0; ddr_valid = 1'b1;
        #2;
        chk("bz_valid1", 64'(o_valid[1]), 64'd1);
        @(negedge clock);
        ddr_valid = 1'b0;
        #2;
        chk("bz_busy", 64'(busy), 64'd0);

        // rd and wr together: read wins
        @(negedge clock);
        q_rd[0] = 1'b1; q_wr[0] = 1'b1; q_bc[0] = 8'd1;
        #2;
        chk("rw_rd", 64'(ddr_rd), 64'd1);
        chk("rw_wr", 64'(ddr_wr), 64'd0);
        @(negedge clock);
        q_rd[0] = 1'b0; q_wr[0] = 1'b0; ddr_valid = 1'b1;
        #2;
        chk("rw_valid0", 64'(o_valid[0]), 64'd1);
        @(negedge clock);
        ddr_valid = 1'b0;
        #2;
        chk("rw_busy", 64'(busy), 64'd0);

        // randomized traffic, checked cycle by cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                q_rd[k]   = ($urandom_range(0, 3) == 0);
                q_wr[k]   = ($urandom_range(0, 2) == 0);
                q_addr[k] = $urandom;
                q_bc[k]   = 8'($urandom_range(0, 5));
                q_mask[k] = 8'($urandom);
                q_din[k]  = {$urandom, $urandom};
            end
            ddr_waitReq = ($urandom_range(0, 2) == 0);
            ddr_valid   = ($urandom_range(0, 1) == 0);
            ddr_dout    = {$urandom, $urandom};
        end
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
